// File: rtl/block_transfer_sequencer.sv
// Job sequencer for the block load/store decoder: loads blocks A..H, kicks the
// compute engine, waits for it, then stores result blocks J..M.
module block_transfer_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int BLOCK_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic                  mem_ready,
    input  logic                  compute_done,
    output logic [4:0]            command,
    output logic                  cmd_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  compute_start,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CSTART,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [4:0] CMD_NOP = 5'b10000;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] srcBase_q, srcBase_d;
    logic [ADDR_WIDTH-1:0] dstBase_q, dstBase_d;
    logic [ADDR_WIDTH-1:0] blockOffset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            srcBase_q <= '0;
            dstBase_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            srcBase_q <= srcBase_d;
            dstBase_q <= dstBase_d;
        end
    end

    // A block index only advances on a memory accept, so a stall re-presents the same block.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        srcBase_d = srcBase_q;
        dstBase_d = dstBase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    srcBase_d = src_base;
                    dstBase_d = dst_base;
                    idx_d     = 3'd0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mem_ready) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = S_CSTART;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_CSTART: state_d = S_WAIT;
            S_WAIT: begin
                if (compute_done) begin
                    idx_d   = 3'd0;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (mem_ready) begin
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign blockOffset = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(BLOCK_STRIDE);

    // Moore outputs: decoded from registered state and index only.
    always_comb begin
        command       = CMD_NOP;
        cmd_valid     = 1'b0;
        mem_addr      = '0;
        compute_start = 1'b0;
        done          = 1'b0;
        busy          = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                command   = {2'b00, idx_q};
                cmd_valid = 1'b1;
                mem_addr  = srcBase_q + blockOffset;
            end
            S_STORE: begin
                command   = {3'b010, idx_q[1:0]};
                cmd_valid = 1'b1;
                mem_addr  = dstBase_q + blockOffset;
            end
            S_CSTART: compute_start = 1'b1;
            S_DONE:   done          = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Scoreboard bench for block_transfer_sequencer: directed jobs push expected
// transfers/pulses into a queue, a negedge monitor pops and compares them.
module tb_block_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic        mem_ready;
    logic        compute_done;
    logic [4:0]  command;
    logic        cmd_valid;
    logic [31:0] mem_addr;
    logic        compute_start;
    logic        busy;
    logic        done;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  cmd;
        logic [31:0] addr;
    } exp_t;

    localparam logic [1:0] K_XFER  = 2'd0;
    localparam logic [1:0] K_START = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;

    exp_t sbq[$];
    exp_t monHead;

    always #5 clk = ~clk;

    block_transfer_sequencer #(
        .ADDR_WIDTH  (32),
        .BLOCK_STRIDE(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .mem_ready    (mem_ready),
        .compute_done (compute_done),
        .command      (command),
        .cmd_valid    (cmd_valid),
        .mem_addr     (mem_addr),
        .compute_start(compute_start),
        .busy         (busy),
        .done         (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nErrors++;
        $display("[TB] FAIL %s: event not observed within cycle budget", name);
    endtask

    task automatic pushJob(input logic [31:0] src, input logic [31:0] dst);
        for (int i = 0; i < 8; i++)
            sbq.push_back('{K_XFER, 5'(i), src + 32'(i * 4)});
        sbq.push_back('{K_START, 5'b10000, 32'h0});
        for (int i = 0; i < 4; i++)
            sbq.push_back('{K_XFER, 5'(8 + i), dst + 32'(i * 4)});
        sbq.push_back('{K_DONE, 5'b10000, 32'h0});
    endtask

    // Monitor: every valid command, compute_start and done must match the queue head in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid) begin
                if (sbq.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL unexpectedCmd: got command 0x%02h addr 0x%08h, expected none", command, mem_addr);
                end else begin
                    monHead = sbq[0];
                    checkOutput("xferKind", 32'(K_XFER), 32'(monHead.kind));
                    checkOutput("command", 32'(command), 32'(monHead.cmd));
                    checkOutput("mem_addr", mem_addr, monHead.addr);
                    if (mem_ready) void'(sbq.pop_front());
                end
            end
            if (compute_start) begin
                if (sbq.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL unexpectedComputeStart: got pulse, expected none");
                end else begin
                    monHead = sbq.pop_front();
                    checkOutput("computeStartOrder", 32'(K_START), 32'(monHead.kind));
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    nChecks++; nErrors++;
                    $display("[TB] FAIL unexpectedDone: got pulse, expected none");
                end else begin
                    monHead = sbq.pop_front();
                    checkOutput("doneOrder", 32'(K_DONE), 32'(monHead.kind));
                end
            end
        end
    end

    // One full job; inputs are driven 1 time unit after each rising edge.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input int stallIdx, input int stallLen, input int waitLen,
                                 input bit pulseInLoad, input bit holdStart);
        int  c;
        int  stalls;
        int  startCyc;
        bit  fin;
        pushJob(src, dst);
        src_base     = src;
        dst_base     = dst;
        start        = 1'b1;
        mem_ready    = 1'b1;
        compute_done = 1'b0;
        @(posedge clk); #1;
        c = 1; stalls = 0; startCyc = -1; fin = 1'b0;
        while (c < 200) begin
            if (compute_start) begin
                startCyc = c;
                checkOutput("computeStartCycle", 32'(c), 32'(9 + stallLen));
            end
            if (done) begin
                checkOutput("doneCycle", 32'(c), 32'(15 + stallLen + waitLen));
                fin = 1'b1;
            end
            mem_ready    = 1'b1;
            compute_done = 1'b0;
            if (!holdStart) start = 1'b0;
            if (fin) break;
            if (cmd_valid && int'(command) == stallIdx && stalls < stallLen) begin
                mem_ready = 1'b0;
                stalls++;
            end
            if (pulseInLoad && cmd_valid && command == 5'd3) compute_done = 1'b1;
            if (startCyc > 0 && c > startCyc) begin
                if (c <= startCyc + waitLen) begin
                    checkOutput("waitNoCmd", 32'(cmd_valid), 32'd0);
                    checkOutput("waitBusy", 32'(busy), 32'd1);
                end else if (c == startCyc + waitLen + 1) begin
                    compute_done = 1'b1;
                end else if (c == startCyc + waitLen + 2) begin
                    checkOutput("storeFirstValid", 32'(cmd_valid), 32'd1);
                    checkOutput("storeFirstCmd", 32'(command), 32'd8);
                end
            end
            @(posedge clk); #1;
            c++;
        end
        if (!fin) failNow("jobTimeout");
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleValid", 32'(cmd_valid), 32'd0);
    endtask

    task automatic abortTest();
        bit found;
        pushJob(32'h700, 32'h800);
        src_base     = 32'h700;
        dst_base     = 32'h800;
        start        = 1'b1;
        mem_ready    = 1'b1;
        compute_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_valid && command == 5'd9) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!found) begin
            failNow("abortReachStore1");
        end else begin
            reset     = 1'b1;
            mem_ready = 1'b0;
            @(posedge clk); #1;
            reset     = 1'b0;
            mem_ready = 1'b1;
            compute_done = 1'b0;
            sbq.delete();
            checkOutput("abortBusy", 32'(busy), 32'd0);
            checkOutput("abortValid", 32'(cmd_valid), 32'd0);
            checkOutput("abortCommand", 32'(command), 32'h10);
            checkOutput("abortAddr", mem_addr, 32'h0);
            checkOutput("abortDone", 32'(done), 32'd0);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                checkOutput("abortStaysIdle", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        src_base     = 32'h0;
        dst_base     = 32'h0;
        mem_ready    = 1'b0;
        compute_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstCommand", 32'(command), 32'h10);
        checkOutput("rstValid", 32'(cmd_valid), 32'd0);
        checkOutput("rstAddr", mem_addr, 32'h0);
        checkOutput("rstComputeStart", 32'(compute_start), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        reset = 1'b0;

        $display("[TB] nominal job");
        applyStimulus(32'h100, 32'h200, -1, 0, 0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] memory stall at load block 2");
        applyStimulus(32'h300, 32'h400, 2, 3, 0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] early compute_done ignored, late completion");
        applyStimulus(32'h500, 32'h600, -1, 0, 5, 1'b1, 1'b0);
        idleCycle();

        $display("[TB] start held high, back-to-back jobs");
        applyStimulus(32'h1000, 32'h2000, -1, 0, 0, 1'b0, 1'b1);
        idleCycle();
        applyStimulus(32'h3000, 32'h4000, -1, 0, 0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] address wrap");
        applyStimulus(32'hFFFF_FFF8, 32'hFFFF_FFFC, -1, 0, 0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] reset during store");
        abortTest();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
